// File: rtl/audio_fir_tdm.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks NUM_TAPS taps per sample,
// with double-buffered coefficients, rounding shift, saturation and per-sample bypass.
module audio_fir_tdm #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int NUM_TAPS    = 64,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = 64,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W = $clog2(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  s_data,
  input  logic        [CH_W-1:0]        s_ch,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          coeff_wr_en,
  input  logic        [TAP_W-1:0]       coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                          coeff_swap,
  input  logic        [5:0]             shift,
  input  logic                          enable,
  output logic signed [DATA_WIDTH-1:0]  m_data,
  output logic        [CH_W-1:0]        m_ch,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SCALE, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  hist_q [NUM_CH][NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [2][NUM_TAPS];
  logic        [TAP_W-1:0]       wp_q   [NUM_CH];
  logic                          active_q, active_d;
  logic                          pending_q, pending_d;
  logic        [CH_W-1:0]        ch_q, ch_d;
  logic        [5:0]             shift_q, shift_d;
  logic        [TAP_W-1:0]       newest_q, newest_d;
  logic        [TAP_W-1:0]       k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic        [CH_W-1:0]        m_ch_q, m_ch_d;

  logic                          accept;
  logic                          ch_ok;
  logic                          hist_we;
  logic        [TAP_W-1:0]       wp_cur, wp_nxt;
  logic        [TAP_W:0]         diff;
  logic        [TAP_W-1:0]       rd_idx;
  logic signed [DATA_WIDTH-1:0]  x_k;
  logic signed [COEFF_WIDTH-1:0] c_k;
  logic signed [PROD_W-1:0]      prod;
  logic                          swap_ok;
  logic                          swap_req;

  // Rounding arithmetic right shift, one guard bit so the bias cannot wrap.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic        [5:0]           sh
  );
    int                          sh_eff;
    logic signed [ACC_WIDTH:0]   ext;
    logic signed [ACC_WIDTH:0]   bias;
    sh_eff = (int'(sh) >= ACC_WIDTH) ? ACC_WIDTH - 1 : int'(sh);
    ext    = {a[ACC_WIDTH-1], a};
    bias   = '0;
    if (sh_eff > 0) bias[sh_eff-1] = 1'b1;
    return (ext + bias) >>> sh_eff;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH:0] r
  );
    logic [ACC_WIDTH-DATA_WIDTH+1:0] top;
    top = r[ACC_WIDTH:DATA_WIDTH-1];
    if ((&top) || !(|top)) return r[DATA_WIDTH-1:0];
    else if (r[ACC_WIDTH]) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                   return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign s_ready = (state_q == S_IDLE) && !rst;
  assign m_valid = (state_q == S_OUT);
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;

  always_comb begin
    accept  = s_valid && s_ready;
    ch_ok   = ({1'b0, s_ch} < (CH_W+1)'(NUM_CH));
    hist_we = accept && ch_ok;
    wp_cur  = wp_q[s_ch];
    wp_nxt  = (wp_cur == TAP_W'(NUM_TAPS-1)) ? '0 : wp_cur + 1'b1;
  end

  // Tap k reads the sample k steps older than the newest one, modulo NUM_TAPS.
  always_comb begin
    diff = {1'b0, newest_q} - {1'b0, k_q};
    if (diff[TAP_W]) rd_idx = TAP_W'(diff + (TAP_W+1)'(NUM_TAPS));
    else             rd_idx = diff[TAP_W-1:0];
    x_k  = hist_q[ch_q][rd_idx];
    c_k  = coef_q[active_q][k_q];
    prod = x_k * c_k;
  end

  // Bank swaps only land between samples so a sample never mixes two banks.
  always_comb begin
    swap_ok   = ((state_q == S_IDLE) && !accept) || ((state_q == S_OUT) && m_ready);
    swap_req  = pending_q || coeff_swap;
    active_d  = active_q;
    pending_d = swap_req;
    if (swap_ok && swap_req) begin
      active_d  = ~active_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shift_d  = shift_q;
    newest_d = newest_q;
    k_d      = k_q;
    acc_d    = acc_q;
    m_data_d = m_data_q;
    m_ch_d   = m_ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && ch_ok) begin
          ch_d     = s_ch;
          shift_d  = shift;
          newest_d = wp_cur;
          if (enable) begin
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end else begin
            m_data_d = s_data;
            m_ch_d   = s_ch;
            state_d  = S_OUT;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        k_d   = k_q + 1'b1;
        if (k_q == TAP_W'(NUM_TAPS-1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        m_data_d = saturate(round_shift(acc_q, shift_q));
        m_ch_d   = ch_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      ch_q      <= '0;
      shift_q   <= '0;
      newest_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wp_q[c] <= '0;
        for (int t = 0; t < NUM_TAPS; t++) hist_q[c][t] <= '0;
      end
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < NUM_TAPS; t++) coef_q[b][t] <= '0;
      end
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ch_q      <= ch_d;
      shift_q   <= shift_d;
      newest_q  <= newest_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
      if (hist_we) begin
        hist_q[s_ch][wp_cur] <= s_data;
        wp_q[s_ch]           <= wp_nxt;
      end
      // Writes use the pre-swap shadow, so a same-cycle write+swap becomes active.
      if (coeff_wr_en) coef_q[~active_q][coeff_wr_addr] <= coeff_wr_data;
    end
  end

endmodule
